// File: rtl/sync_rr_arbiter.sv
// Clocked round-robin arbiter: M four-phase bundled-data requesters share one
// four-phase output channel; every output is registered.
//
//  state | meaning
//  IDLE  | no grant; choose the next requester round-robin from ptr
//  SETUP | data and grant captured, r_o rises next edge
//  REQ   | r_o high, waiting for the consumer ack
//  ACK   | a_i[idx] high, waiting for the requester to drop r_i[idx]
//  RTZ   | r_o low, waiting for the consumer ack to return to zero
module sync_rr_arbiter #(
    parameter int N    = 8,
    parameter int M    = 4,
    parameter bit SYNC = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   r_i,
    output logic [M-1:0]   a_i,
    input  logic [M*N-1:0] d_i,
    output logic           r_o,
    input  logic           a_o,
    output logic [N-1:0]   d_o,
    output logic [M-1:0]   gnt_o,
    output logic           busy_o
);

    localparam int PW = (M > 1) ? $clog2(M) : 1;
    localparam logic [PW-1:0] LAST = PW'(M - 1);
    localparam logic [PW:0]   M_EXT = (PW + 1)'(M);

    typedef enum logic [2:0] {IDLE, SETUP, REQ, ACK, RTZ} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  ptr, ptr_nxt, idx, idx_nxt, sel;
    logic           sel_vld;
    logic [M-1:0]   rs, a_i_nxt, gnt_nxt;
    logic           as_s, r_o_nxt, busy_nxt;
    logic [N-1:0]   d_o_nxt;
    logic [N-1:0]   d_arr [M];
    logic [PW:0]    cand;

    generate
        if (SYNC) begin : g_sync
            logic [M-1:0] r_m1, r_m2;
            logic         a_m1, a_m2;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_m1 <= '0;
                    r_m2 <= '0;
                    a_m1 <= 1'b0;
                    a_m2 <= 1'b0;
                end else begin
                    r_m1 <= r_i;
                    r_m2 <= r_m1;
                    a_m1 <= a_o;
                    a_m2 <= a_m1;
                end
            end
            assign rs   = r_m2;
            assign as_s = a_m2;
        end else begin : g_nosync
            assign rs   = r_i;
            assign as_s = a_o;
        end
    endgenerate

    for (genvar g = 0; g < M; g++) begin : g_unpack
        assign d_arr[g] = d_i[g*N +: N];
    end

    // First active request at or after ptr, wrapping modulo M (M need not be 2^k).
    always_comb begin
        sel_vld = 1'b0;
        sel     = ptr;
        cand    = '0;
        for (int j = 0; j < M; j++) begin
            cand = {1'b0, ptr} + (PW + 1)'(j);
            if (cand >= M_EXT) cand = cand - M_EXT;
            if (!sel_vld && rs[cand[PW-1:0]]) begin
                sel_vld = 1'b1;
                sel     = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        r_o_nxt   = r_o;
        a_i_nxt   = a_i;
        d_o_nxt   = d_o;
        gnt_nxt   = gnt_o;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    idx_nxt      = sel;
                    d_o_nxt      = d_arr[sel];
                    gnt_nxt      = '0;
                    gnt_nxt[sel] = 1'b1;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                r_o_nxt   = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                if (as_s) begin
                    a_i_nxt[idx] = 1'b1;
                    state_nxt    = ACK;
                end
            end
            ACK: begin
                // A requester that already dropped its request lets this pass at once.
                if (!rs[idx]) begin
                    r_o_nxt   = 1'b0;
                    state_nxt = RTZ;
                end
            end
            RTZ: begin
                if (!as_s) begin
                    a_i_nxt   = '0;
                    gnt_nxt   = '0;
                    ptr_nxt   = (idx == LAST) ? '0 : idx + PW'(1);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            r_o    <= 1'b0;
            a_i    <= '0;
            d_o    <= '0;
            gnt_o  <= '0;
            busy_o <= 1'b0;
            ptr    <= '0;
            idx    <= '0;
        end else begin
            state  <= state_nxt;
            r_o    <= r_o_nxt;
            a_i    <= a_i_nxt;
            d_o    <= d_o_nxt;
            gnt_o  <= gnt_nxt;
            busy_o <= busy_nxt;
            ptr    <= ptr_nxt;
            idx    <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// Bench for sync_rr_arbiter (SYNC=0, M=4, N=8): requester and consumer models
// plus a grant scoreboard and per-cycle handshake checks.
module tb_sync_rr_arbiter;

    localparam int N = 8;
    localparam int M = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [M-1:0]   r_i, a_i, gnt_o;
    logic [M*N-1:0] d_i;
    logic           r_o, a_o, busy_o;
    logic [N-1:0]   d_o;

    logic [M-1:0]   r_mod = '0;
    logic [M-1:0]   r_man = '0;
    logic           cons_a = 1'b0;
    logic           spur_a = 1'b0;
    logic           cons_en = 1'b1;
    int             cons_cnt = 0;
    int             cons_dly = 1;
    logic [N-1:0]   dat [M];
    int             req_cnt [M];
    int             done_cnt [M];

    int             n_chk = 0;
    int             n_err = 0;
    logic [15:0]    exp_q [$];

    assign r_i = r_mod | r_man;
    assign a_o = cons_a | spur_a;

    always_comb begin
        d_i = '0;
        for (int k = 0; k < M; k++) d_i[k*N +: N] = dat[k];
    end

    always #5 clk = ~clk;

    sync_rr_arbiter #(.N(N), .M(M), .SYNC(1'b0)) dut (
        .clk    (clk),
        .rst    (rst),
        .r_i    (r_i),
        .a_i    (a_i),
        .d_i    (d_i),
        .r_o    (r_o),
        .a_o    (a_o),
        .d_o    (d_o),
        .gnt_o  (gnt_o),
        .busy_o (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Requester k raises r_i[k] while it owes transfers, drops it once a_i[k] is seen.
    always @(negedge clk) begin
        if (rst) begin
            r_mod = '0;
            for (int k = 0; k < M; k++) done_cnt[k] = req_cnt[k];
        end else begin
            for (int k = 0; k < M; k++) begin
                if (r_mod[k] && a_i[k]) begin
                    r_mod[k] = 1'b0;
                    done_cnt[k]++;
                end else if (!r_mod[k] && !a_i[k] && done_cnt[k] < req_cnt[k]) begin
                    r_mod[k] = 1'b1;
                end
            end
        end
    end

    // Consumer: acks cons_dly samples after seeing r_o, releases once r_o falls.
    always @(negedge clk) begin
        if (rst || !r_o) begin
            cons_a   = 1'b0;
            cons_cnt = 0;
        end else if (cons_en && !cons_a) begin
            if (cons_cnt >= cons_dly) cons_a = 1'b1;
            else cons_cnt++;
        end
    end

    // Monitor samples just after the edge; inputs then equal what the DUT just saw.
    logic [M-1:0] p_gnt = '0;
    logic [M-1:0] p_ai  = '0;
    logic         p_ro  = 1'b0;
    logic [N-1:0] p_do  = '0;
    int           cyc = 0;
    int           gnt_cyc = 0;
    logic [15:0]  e;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            chk("ai_onehot0", 32'($onehot0(a_i)), 32'd1);
            chk("ai_only_granted", 32'(a_i & ~gnt_o), 32'd0);
            chk("ro_only_busy", 32'(r_o & ~busy_o), 32'd0);
            if (gnt_o != '0 && p_gnt == '0) begin
                gnt_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_gnt", 32'(gnt_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_gnt", 32'(gnt_o), 32'd1 << e[15:8]);
                    chk("sb_data", 32'(d_o), 32'(e[7:0]));
                end
            end
            if (r_o && !p_ro) begin
                chk("setup_len", 32'(cyc - gnt_cyc), 32'd1);
                chk("setup_data_stable", 32'(d_o), 32'(p_do));
            end
            if (a_i != '0 && p_ai == '0) chk("ai_rise_needs_ao", 32'(a_o), 32'd1);
            if (a_i == '0 && p_ai != '0) chk("ai_fall_needs_ao_low", 32'(a_o), 32'd0);
            if (!r_o && p_ro) chk("ro_fall_needs_ri_low", 32'(r_i & p_gnt), 32'd0);
        end
        p_gnt = gnt_o;
        p_ai  = a_i;
        p_ro  = r_o;
        p_do  = d_o;
    end

    function automatic bit all_done();
        bit ok = (exp_q.size() == 0) && !busy_o && (r_i == '0) && !a_o;
        for (int k = 0; k < M; k++) if (done_cnt[k] != req_cnt[k]) ok = 1'b0;
        return ok;
    endfunction

    task automatic wait_done(input int lim, input string tag);
        int i = 0;
        while (!all_done() && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(all_done()), 32'd1);
    endtask

    task automatic wait_ro(input logic v, input int lim, input string tag);
        int i = 0;
        while (r_o !== v && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(r_o), 32'(v));
    endtask

    task automatic req(input int k, input logic [N-1:0] d);
        dat[k] = d;
        req_cnt[k]++;
        exp_q.push_back({8'(k), d});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_r_o"}, 32'(r_o), 32'd0);
        chk({tag, "_a_i"}, 32'(a_i), 32'd0);
        chk({tag, "_d_o"}, 32'(d_o), 32'd0);
        chk({tag, "_gnt"}, 32'(gnt_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_ptr"}, 32'(dut.ptr), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit saw;
        for (int k = 0; k < M; k++) begin
            dat[k]      = '0;
            req_cnt[k]  = 0;
            done_cnt[k] = 0;
        end

        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single transfer from requester 0
        req(0, 8'hA5);
        wait_done(40, "single_done");
        chk("single_ptr", 32'(dut.ptr), 32'd1);
        chk("single_dout_held", 32'(d_o), 32'hA5);

        // Reset held two cycles in the middle of REQ
        cons_en = 1'b0;
        req(2, 8'h5A);
        wait_ro(1'b1, 20, "rst_reach_req");
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midreq_rst");
        @(negedge clk);
        chk_reset_outputs("midreq_rst2");
        rst = 1'b0;
        cons_en = 1'b1;
        repeat (2) @(negedge clk);
        wait_done(20, "rst_quiet");

        // Fairness with all four requesting and re-raising
        for (int k = 0; k < M; k++) dat[k] = 8'h10 + 8'(k);
        req(0, 8'h10); req(1, 8'h11); req(2, 8'h12); req(3, 8'h13);
        req(0, 8'h10); req(1, 8'h11);
        wait_done(200, "fair_done");
        chk("fair_ptr", 32'(dut.ptr), 32'd2);

        // Wrap and priority from ptr=3
        req(2, 8'h12);
        wait_done(40, "wrap_pre_done");
        chk("wrap_ptr3", 32'(dut.ptr), 32'd3);
        req(3, 8'h33);
        req(0, 8'h30);
        wait_done(80, "wrap_done");
        chk("wrap_ptr1", 32'(dut.ptr), 32'd1);
        req(1, 8'h41);
        req(0, 8'h40);
        wait_done(80, "prio_done");
        chk("prio_ptr1", 32'(dut.ptr), 32'd1);

        // Consumer stall in REQ with a new arrival on requester 2
        cons_en = 1'b0;
        req(1, 8'h77);
        wait_ro(1'b1, 20, "stall_reach_req");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) req(2, 8'h2B);
            chk("stall_r_o", 32'(r_o), 32'd1);
            chk("stall_a_i", 32'(a_i), 32'd0);
            chk("stall_d_o", 32'(d_o), 32'h77);
            chk("stall_gnt", 32'(gnt_o), 32'b0010);
        end
        cons_en = 1'b1;
        wait_done(80, "stall_done");
        chk("stall_ptr", 32'(dut.ptr), 32'd3);

        // Request withdrawn in SETUP: transfer still completes with captured data
        dat[0] = 8'hC3;
        r_man[0] = 1'b1;
        exp_q.push_back({8'd0, 8'hC3});
        for (int i = 0; i < 10 && gnt_o == '0; i++) @(negedge clk);
        chk("viol_gnt", 32'(gnt_o), 32'b0001);
        r_man[0] = 1'b0;
        dat[0] = 8'hFF;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_i[0]) saw = 1'b1;
            if (saw && !busy_o) break;
        end
        chk("viol_ack_seen", 32'(saw), 32'd1);
        chk("viol_idle", 32'(busy_o), 32'd0);
        chk("viol_d_o", 32'(d_o), 32'hC3);
        chk("viol_ptr", 32'(dut.ptr), 32'd1);

        // Spurious consumer ack while idle
        @(negedge clk);
        spur_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("spur_busy", 32'(busy_o), 32'd0);
            chk("spur_r_o", 32'(r_o), 32'd0);
            chk("spur_a_i", 32'(a_i), 32'd0);
        end
        spur_a = 1'b0;
        req(3, 8'h99);
        wait_done(40, "post_spur_done");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
